// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode/state enums, flag bit positions and flag packing helper for alu_seq
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_NOT  = 3'b011,
        OP_CLR  = 3'b100,
        OP_OR   = 3'b101,
        OP_AND  = 3'b110,
        OP_MUL  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_e;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    // Places the four status bits at their fixed positions in the flags word.
    function automatic logic [3:0] mk_flags(input logic v, input logic c, input logic n, input logic z);
        logic [3:0] f;
        f        = '0;
        f[FLG_V] = v;
        f[FLG_C] = c;
        f[FLG_N] = n;
        f[FLG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add unsigned multiplier, one multiplier bit per cycle
module alu_seq_mul #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d;

    assign done    = done_q;
    assign product = prod_q;

    // Bit 0 is folded in on the start edge, so the last bit lands WIDTH-1 edges later and done pulses right after it.
    always_comb begin
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (start) begin
            prod_d   = b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_d  = {{WIDTH{1'b0}}, a} << 1;
            mplier_d = b >> 1;
            cnt_d    = CNT_W'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            busy_d   = cnt_q != CNT_W'(WIDTH - 1);
            done_d   = cnt_q == CNT_W'(WIDTH - 1);
        end
    end

    // Iteration state; reset abandons any multiply in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with accumulator operand, registered flags and iterative multiply
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int  WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_sel,
    input  logic             use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags
);

    state_e             state_q;
    logic [WIDTH-1:0]   res_q, acc_q, res_d, opa, mul_res;
    logic [3:0]         flg_q, flg_d, mul_flg;
    logic [WIDTH:0]     sum, dif;
    logic [2*WIDTH-1:0] product;
    logic               accept, handoff, mul_done, c, v;
    alu_op_e            op;

    assign op        = alu_op_e'(alu_sel);
    assign out_valid = state_q == DONE;
    assign handoff   = out_valid && out_ready;
    assign in_ready  = (state_q == IDLE) || handoff;
    assign accept    = in_valid && in_ready;
    assign alu_out   = res_q;
    assign flags     = flg_q;

    // A result being handed off this cycle is the value acc is about to take, so forward it.
    assign opa = use_acc ? (handoff ? res_q : acc_q) : a;
    assign sum = {1'b0, opa} + {1'b0, b};
    assign dif = {1'b0, opa} - {1'b0, b};

    assign mul_res = product[WIDTH-1:0];
    assign mul_flg = mk_flags(1'b0, |product[2*WIDTH-1:WIDTH], mul_res[WIDTH-1], mul_res == '0);

    alu_seq_mul #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && op == OP_MUL),
        .a       (opa),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    // Single-cycle result and flags; borrow-free subtract reads as carry set.
    always_comb begin
        res_d = opa;
        c     = 1'b0;
        v     = 1'b0;
        case (op)
            OP_ADD: begin
                res_d = sum[WIDTH-1:0];
                c     = sum[WIDTH];
                v     = (opa[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = dif[WIDTH-1:0];
                c     = ~dif[WIDTH];
                v     = (opa[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_NOT:  res_d = ~opa;
            OP_CLR:  res_d = '0;
            OP_OR:   res_d = opa | b;
            OP_AND:  res_d = opa & b;
            default: res_d = opa;
        endcase
        flg_d = mk_flags(v, c, res_d[WIDTH-1], res_d == '0);
    end

    // Control FSM with registered result, flags and accumulator; acc moves only on an output handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            flg_q   <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (handoff)
                        acc_q <= res_q;
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state_q <= MUL;
                        end else begin
                            state_q <= DONE;
                            res_q   <= res_d;
                            flg_q   <= flg_d;
                        end
                    end else if (handoff) begin
                        state_q <= IDLE;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state_q <= DONE;
                        res_q   <= mul_res;
                        flg_q   <= mul_flg;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a behavioural model
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, ir, ua, ov, ordy;
    logic [15:0] a16, b16, out16;
    logic [2:0]  sel;
    logic [3:0]  fl16;
    logic        iv8, ir8, ua8, ov8, ordy8;
    logic [7:0]  a8, b8, out8;
    logic [2:0]  sel8;
    logic [3:0]  fl8;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a16), .b(b16),
        .alu_sel(sel), .use_acc(ua), .out_valid(ov), .out_ready(ordy),
        .alu_out(out16), .flags(fl16)
    );

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .alu_sel(sel8), .use_acc(ua8), .out_valid(ov8), .out_ready(ordy8),
        .alu_out(out8), .flags(fl8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Spec-level model: returns {V,C,N,Z, result} for a w-bit operation using full-precision arithmetic.
    function automatic logic [35:0] model(input int w, input logic [2:0] op, input longint unsigned x, input longint unsigned y);
        longint unsigned m, r, p;
        longint          sx, sy, s, hi, lo;
        logic            c, v, n, z;
        m  = (64'd1 << w) - 1;
        x  = x & m;
        y  = y & m;
        hi = longint'(m >> 1);
        lo = -hi - 1;
        sx = longint'(x);
        sy = longint'(y);
        if (sx > hi) sx = sx - longint'(m) - 1;
        if (sy > hi) sy = sy - longint'(m) - 1;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            3'd0: r = x;
            3'd1: begin r = (x + y) & m; c = (x + y) > m; s = sx + sy; v = s > hi || s < lo; end
            3'd2: begin r = (x - y) & m; c = x >= y; s = sx - sy; v = s > hi || s < lo; end
            3'd3: r = ~x & m;
            3'd4: r = 0;
            3'd5: r = x | y;
            3'd6: r = x & y;
            default: begin p = x * y; r = p & m; c = p > m; end
        endcase
        n = ((r >> (w - 1)) & 1) != 0;
        z = r == 0;
        return {v, c, n, z, 32'(r)};
    endfunction

    // Scoreboard for the 16-bit instance: at most one pending result with its due cycle.
    logic            armed = 1'b0, pend = 1'b0, mv, acc_in;
    int              cyc = 0, due = 0;
    logic [31:0]     er;
    logic [3:0]      ef;
    logic [35:0]     mr;
    longint unsigned accm = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pend  = 1'b0;
            accm  = 0;
            armed = 1'b1;
        end else if (armed) begin
            mv = pend && cyc >= due;
            chk("mon out_valid", ov, mv);
            chk("mon in_ready", ir, !pend || (mv && ordy));
            if (mv) begin
                chk("mon alu_out", out16, er);
                chk("mon flags", fl16, ef);
            end
            acc_in = iv && (!pend || (mv && ordy));
            if (mv && ordy) begin
                accm = er;
                pend = 1'b0;
            end
            if (acc_in) begin
                mr   = model(16, sel, ua ? accm : longint'(a16), b16);
                er   = mr[31:0];
                ef   = mr[35:32];
                pend = 1'b1;
                due  = cyc + (sel == 3'd7 ? 17 : 1);
            end
        end
    end

    task automatic do_op(input int w, input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                         input logic u, input int hold, input logic [15:0] eres, input logic [3:0] efl,
                         input int elat, input string nm);
        int lat;
        @(posedge clk); #1;
        if (w == 8) begin iv8 = 1; sel8 = op; a8 = x[7:0]; b8 = y[7:0]; ua8 = u; ordy8 = 0; end
        else begin iv = 1; sel = op; a16 = x; b16 = y; ua = u; ordy = 0; end
        @(negedge clk);
        chk({nm, " in_ready"}, w == 8 ? ir8 : ir, 1);
        @(posedge clk); #1;
        iv  = 0;
        iv8 = 0;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (w == 8 ? ov8 : ov) break;
        end
        chk({nm, " latency"}, lat, elat);
        chk({nm, " alu_out"}, w == 8 ? {8'h0, out8} : out16, eres);
        chk({nm, " flags"}, w == 8 ? fl8 : fl16, efl);
        repeat (hold) begin
            @(negedge clk);
            chk({nm, " hold alu_out"}, w == 8 ? {8'h0, out8} : out16, eres);
            chk({nm, " hold flags"}, w == 8 ? fl8 : fl16, efl);
            chk({nm, " hold in_ready"}, w == 8 ? ir8 : ir, 0);
            chk({nm, " hold out_valid"}, w == 8 ? ov8 : ov, 1);
        end
        @(posedge clk); #1;
        ordy  = 1;
        ordy8 = 1;
        @(posedge clk); #1;
        ordy  = 0;
        ordy8 = 0;
    endtask

    initial begin
        logic seen;
        rst = 1; iv = 1; sel = 3'd1; a16 = 16'h1234; b16 = 16'h0101; ua = 0; ordy = 0;
        iv8 = 1; sel8 = 3'd1; a8 = 8'h12; b8 = 8'h01; ua8 = 0; ordy8 = 0;

        chk("model add carry", model(16, 3'd1, 64'hFFFF, 64'h1), {4'b0101, 32'h0});
        chk("model add ovf", model(16, 3'd1, 64'h7FFF, 64'h1), {4'b1010, 32'h8000});
        chk("model sub", model(16, 3'd2, 64'h3, 64'h5), {4'b0010, 32'hFFFE});
        chk("model mul8", model(8, 3'd7, 64'h10, 64'h10), {4'b0101, 32'h0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", ov, 0);
        chk("rst alu_out", out16, 0);
        chk("rst flags", fl16, 0);
        chk("rst in_ready", ir, 1);
        chk("rst8 out_valid", ov8, 0);
        chk("rst8 in_ready", ir8, 1);
        @(posedge clk); #1;
        rst = 0; iv = 0; iv8 = 0;

        do_op(16, 3'd1, 16'h5555, 16'h0000, 1, 0, 16'h0000, 4'b0001, 1, "add_acc0");
        do_op(16, 3'd1, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 4'b0101, 1, "add_carry");
        do_op(16, 3'd1, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 4'b1010, 1, "add_ovf");
        do_op(16, 3'd2, 16'h0003, 16'h0005, 0, 5, 16'hFFFE, 4'b0010, 1, "sub_hold");
        do_op(16, 3'd7, 16'h0100, 16'h0100, 0, 0, 16'h0000, 4'b0101, 17, "mul_hi");
        do_op(16, 3'd7, 16'h0003, 16'h0005, 0, 0, 16'h000F, 4'b0000, 17, "mul_small");
        do_op(16, 3'd3, 16'h00F0, 16'h0000, 0, 0, 16'hFF0F, 4'b0010, 1, "not");

        // back-to-back accumulator chain with out_ready held high
        @(posedge clk); #1;
        ordy = 1; iv = 1; sel = 3'd1; a16 = 16'h0002; b16 = 16'h0003; ua = 0;
        @(posedge clk); #1;
        ua = 1; a16 = 16'hDEAD; b16 = 16'h0004;
        @(negedge clk);
        chk("chain first", out16, 16'h0005);
        chk("chain first valid", ov, 1);
        chk("chain b2b ready", ir, 1);
        @(posedge clk); #1;
        iv = 0;
        @(negedge clk);
        chk("chain second", out16, 16'h0009);
        chk("chain second valid", ov, 1);
        @(posedge clk); #1;
        ordy = 0; ua = 0;

        // reset on the sixth cycle of a multiply
        @(posedge clk); #1;
        iv = 1; sel = 3'd7; a16 = 16'h0003; b16 = 16'h0005;
        @(posedge clk); #1;
        iv = 0;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("midrst in_ready", ir, 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov) seen = 1;
        end
        chk("midrst no output", seen, 0);
        do_op(16, 3'd1, 16'h1111, 16'h0000, 1, 0, 16'h0000, 4'b0001, 1, "midrst acc");

        do_op(8, 3'd1, 16'h00FF, 16'h0001, 0, 0, 16'h0000, 4'b0101, 1, "w8 add_carry");
        do_op(8, 3'd1, 16'h007F, 16'h0001, 0, 0, 16'h0080, 4'b1010, 1, "w8 add_ovf");
        do_op(8, 3'd2, 16'h0003, 16'h0005, 0, 5, 16'h00FE, 4'b0010, 1, "w8 sub_hold");
        do_op(8, 3'd7, 16'h0010, 16'h0010, 0, 0, 16'h0000, 4'b0101, 9, "w8 mul_hi");
        do_op(8, 3'd7, 16'h0003, 16'h0005, 0, 0, 16'h000F, 4'b0000, 9, "w8 mul_small");

        // randomized traffic; the monitor checks every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            iv   = $urandom_range(0, 9) < 7;
            sel  = 3'($urandom);
            a16  = $urandom_range(0, 3) == 0 ? 16'hFFFF : ($urandom_range(0, 3) == 0 ? 16'h7FFF : 16'($urandom));
            b16  = $urandom_range(0, 3) == 0 ? 16'h0001 : 16'($urandom);
            ua   = 1'($urandom_range(0, 1));
            ordy = $urandom_range(0, 9) < 6;
            rst  = $urandom_range(0, 299) == 0;
        end
        @(posedge clk); #1;
        rst = 0; iv = 0; ordy = 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
